aes_job_sched: RTL



---
 rtl/aes_sched_pkg.sv | 20 ++
 rtl/aes_rr_arb2.sv | 15 +
 rtl/aes_job_sched.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/aes_sched_pkg.sv
// Shared types and constants for the two-client AES job scheduler.
package aes_sched_pkg;

  localparam int unsigned AES_BLK_W             = 128;
  localparam int unsigned AES_SCHED_TIMEOUT_DEF = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    RESP = 2'd2
  } sched_state_t;

  // Result payload returned to the clients
  typedef struct packed {
    logic                 id;
    logic                 timeout;
    logic [AES_BLK_W-1:0] data;
  } sched_rsp_t;

endpackage

// File: rtl/aes_rr_arb2.sv
// Two-way round-robin grant: on contention the client that did not win last time is granted.
module aes_rr_arb2 (
  input  logic [1:0] i_valid,
  input  logic       i_last_grant,
  output logic [1:0] o_grant_c
);

  always_comb begin
    o_grant_c = i_valid;
    if (i_valid == 2'b11) begin
      o_grant_c = i_last_grant ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/aes_job_sched.sv
// Round-robin job scheduler in front of a single shared AES_top core; holds core inputs
// stable while AES_en is high and returns the ciphertext (or a timeout) tagged with the client ID.
module aes_job_sched
  import aes_sched_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = AES_SCHED_TIMEOUT_DEF
) (
  input  logic                 AES_clk,
  input  logic                 AES_rst_n,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [AES_BLK_W-1:0] req0_data,
  input  logic [AES_BLK_W-1:0] req0_key,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [AES_BLK_W-1:0] req1_data,
  input  logic [AES_BLK_W-1:0] req1_key,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_id,
  output logic [AES_BLK_W-1:0] rsp_data,
  output logic                 rsp_timeout,
  output logic                 core_en,
  output logic [AES_BLK_W-1:0] core_data_in,
  output logic [AES_BLK_W-1:0] core_key_in,
  input  logic [AES_BLK_W-1:0] core_data_out,
  input  logic                 core_data_out_valid,
  output logic                 busy
);

  localparam int unsigned     CNT_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  sched_state_t         r_state,      w_state_nxt;
  logic                 r_last_grant, w_last_grant_nxt;
  logic [CNT_W-1:0]     r_cnt,        w_cnt_nxt;
  logic                 r_core_en,    w_core_en_nxt;
  logic [AES_BLK_W-1:0] r_core_data,  w_core_data_nxt;
  logic [AES_BLK_W-1:0] r_core_key,   w_core_key_nxt;
  logic                 r_rsp_valid,  w_rsp_valid_nxt;
  sched_rsp_t           r_rsp,        w_rsp_nxt;

  logic [1:0]           w_grant;
  logic [1:0]           w_grant_idle;

  aes_rr_arb2 u_arb (
    .i_valid      ({req1_valid, req0_valid}),
    .i_last_grant (r_last_grant),
    .o_grant_c    (w_grant)
  );

  // Grants only count while the core is free
  assign w_grant_idle = (r_state == IDLE) ? w_grant : 2'b00;

  always_ff @(posedge AES_clk or negedge AES_rst_n) begin
    if (!AES_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge AES_clk or negedge AES_rst_n) begin
    if (!AES_rst_n) begin
      r_last_grant <= 1'b1;
      r_cnt        <= '0;
      r_core_en    <= 1'b0;
      r_core_data  <= '0;
      r_core_key   <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp        <= '0;
    end else begin
      r_last_grant <= w_last_grant_nxt;
      r_cnt        <= w_cnt_nxt;
      r_core_en    <= w_core_en_nxt;
      r_core_data  <= w_core_data_nxt;
      r_core_key   <= w_core_key_nxt;
      r_rsp_valid  <= w_rsp_valid_nxt;
      r_rsp        <= w_rsp_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_last_grant_nxt = r_last_grant;
    w_cnt_nxt        = r_cnt;
    w_core_en_nxt    = r_core_en;
    w_core_data_nxt  = r_core_data;
    w_core_key_nxt   = r_core_key;
    w_rsp_valid_nxt  = r_rsp_valid;
    w_rsp_nxt        = r_rsp;

    unique case (r_state)
      IDLE: begin
        if (|w_grant_idle) begin
          w_core_data_nxt  = w_grant_idle[1] ? req1_data : req0_data;
          w_core_key_nxt   = w_grant_idle[1] ? req1_key  : req0_key;
          w_rsp_nxt.id     = w_grant_idle[1];
          w_last_grant_nxt = w_grant_idle[1];
          w_cnt_nxt        = '0;
          w_core_en_nxt    = 1'b1;
          w_state_nxt      = RUN;
        end
      end
      RUN: begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
        // A core valid on the terminal count still counts as a completed job
        if (core_data_out_valid) begin
          w_rsp_nxt.data    = core_data_out;
          w_rsp_nxt.timeout = 1'b0;
          w_rsp_valid_nxt   = 1'b1;
          w_core_en_nxt     = 1'b0;
          w_state_nxt       = RESP;
        end else if (r_cnt == CNT_LAST) begin
          w_rsp_nxt.data    = '0;
          w_rsp_nxt.timeout = 1'b1;
          w_rsp_valid_nxt   = 1'b1;
          w_core_en_nxt     = 1'b0;
          w_state_nxt       = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          w_rsp_valid_nxt = 1'b0;
          w_state_nxt     = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign req0_ready   = w_grant_idle[0];
  assign req1_ready   = w_grant_idle[1];
  assign busy         = (r_state != IDLE);
  assign core_en      = r_core_en;
  assign core_data_in = r_core_data;
  assign core_key_in  = r_core_key;
  assign rsp_valid    = r_rsp_valid;
  assign rsp_id       = r_rsp.id;
  assign rsp_timeout  = r_rsp.timeout;
  assign rsp_data     = r_rsp.data;

endmodule
